// File: rtl/sm_arith_pkg.sv
// Shared signed-magnitude helpers, FSM state encoding and flag-bus bit indices
// for the W-parameterised calculator ALU operations.
package sm_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } sm_state_t;

    localparam int FLAG_ZF  = 3;
    localparam int FLAG_EF  = 2;
    localparam int FLAG_OF  = 1;
    localparam int FLAG_DZF = 0;

    // Helpers work on a 64-bit carrier; callers cast to their own width w.
    function automatic logic sm_sign(input logic [63:0] x, input int w);
        logic [63:0] t;
        t = x >> (w - 1);
        return t[0];
    endfunction

    function automatic logic [63:0] sm_mag(input logic [63:0] x, input int w);
        return x & ((64'd1 << (w - 1)) - 64'd1);
    endfunction

    function automatic logic [63:0] sm_pack(input logic s, input logic [63:0] mag, input int w);
        logic [63:0] m;
        m = sm_mag(mag, w);
        return (m == 64'd0) ? 64'd0 : (m | (64'(s) << (w - 1)));
    endfunction

endpackage

// File: rtl/sm_flag_gen.sv
// Combinational status flags from a result magnitude and a divisor magnitude;
// shared by the signed-magnitude ALU operations.
module sm_flag_gen
    import sm_arith_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-2:0] r_mag,
    input  logic [W-2:0] b_mag,
    output logic         zf,
    output logic         ef,
    output logic         of,
    output logic         dzf
);

    assign zf  = (r_mag == '0);
    assign ef  = ~r_mag[0];
    assign of  = r_mag[0];
    assign dzf = (b_mag == '0);

endmodule

// File: rtl/sm_divrem_seq.sv
// Multi-cycle signed-magnitude divider: restoring shift-subtract, one quotient
// bit per cycle, valid/ready on both sides, truncating sign rules.
module sm_divrem_seq
    import sm_arith_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] q,
    output logic [W-1:0] r,
    output logic         zf,
    output logic         ef,
    output logic         of,
    output logic         dzf
);

    localparam int M  = W - 1;
    localparam int CW = $clog2(M);

    sm_state_t state, state_nxt;

    logic [M-1:0]  dvd;
    logic [M-1:0]  dvs;
    logic [M-1:0]  part;
    logic          sign_a;
    logic          sign_b;
    logic [CW-1:0] cnt;

    logic [M-1:0]  a_mag_in;
    logic [M-1:0]  b_mag_in;
    logic [M:0]    trial;
    logic          take;
    logic [M-1:0]  part_step;
    logic [M-1:0]  dvd_step;
    logic          accept;
    logic          load_out;
    logic [W-1:0]  q_nxt;
    logic [W-1:0]  r_nxt;
    logic          zf_c, ef_c, of_c, dzf_c;

    assign a_mag_in = M'(sm_mag(64'(a), W));
    assign b_mag_in = M'(sm_mag(64'(b), W));

    // dvd holds the unconsumed dividend bits and collects quotient bits from the bottom.
    always_comb begin
        trial     = {part, dvd[M-1]};
        take      = (trial >= {1'b0, dvs});
        part_step = take ? M'(trial - {1'b0, dvs}) : trial[M-1:0];
        dvd_step  = {dvd[M-2:0], take};
    end

    assign q_nxt = W'(sm_pack(sign_a ^ sign_b, 64'(dvd), W));
    assign r_nxt = W'(sm_pack(sign_a, 64'(part), W));

    sm_flag_gen #(.W(W)) u_flag_gen (
        .r_mag (part),
        .b_mag (dvs),
        .zf    (zf_c),
        .ef    (ef_c),
        .of    (of_c),
        .dzf   (dzf_c)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid) state_nxt = (b_mag_in == '0) ? ST_DONE : ST_CALC;
            ST_CALC: if (cnt == '0) state_nxt = ST_DONE;
            ST_DONE: if (out_valid && out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = rst || (state == ST_IDLE);
        accept   = !rst && (state == ST_IDLE) && in_valid;
        load_out = (state == ST_DONE) && !out_valid;
    end

    // A zero divisor skips CALC: quotient stays 0 and the dividend is the remainder.
    always_ff @(posedge clk) begin
        if (accept) begin
            sign_a <= sm_sign(64'(a), W);
            sign_b <= sm_sign(64'(b), W);
            dvs    <= b_mag_in;
            cnt    <= CW'(M - 1);
            if (b_mag_in == '0) begin
                dvd  <= '0;
                part <= a_mag_in;
            end else begin
                dvd  <= a_mag_in;
                part <= '0;
            end
        end else if (state == ST_CALC) begin
            part <= part_step;
            dvd  <= dvd_step;
            cnt  <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            q         <= '0;
            r         <= '0;
            zf        <= 1'b0;
            ef        <= 1'b0;
            of        <= 1'b0;
            dzf       <= 1'b0;
        end else if (load_out) begin
            out_valid <= 1'b1;
            q         <= q_nxt;
            r         <= r_nxt;
            zf        <= zf_c;
            ef        <= ef_c;
            of        <= of_c;
            dzf       <= dzf_c;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sm_divrem_seq.sv
// Bench for sm_divrem_seq at W=8 (directed + random) and W=4 (exhaustive),
// against an arithmetic signed-magnitude reference model.
module tb_sm_divrem_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iv = 1'b0;
    logic       ordy = 1'b0;
    logic [7:0] a_d = '0;
    logic [7:0] b_d = '0;
    bit         sel = 1'b0;

    logic       iry8, ov8, zf8, ef8, of8, dzf8;
    logic [7:0] q8, r8;
    logic       iry4, ov4, zf4, ef4, of4, dzf4;
    logic [3:0] q4, r4;

    logic       iry_v, ov_v;
    logic [7:0] q_v, r_v;
    logic [3:0] fl_v;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sm_divrem_seq #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv && !sel), .in_ready(iry8),
        .a(a_d), .b(b_d), .out_valid(ov8), .out_ready(ordy && !sel),
        .q(q8), .r(r8), .zf(zf8), .ef(ef8), .of(of8), .dzf(dzf8)
    );

    sm_divrem_seq #(.W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv && sel), .in_ready(iry4),
        .a(a_d[3:0]), .b(b_d[3:0]), .out_valid(ov4), .out_ready(ordy && sel),
        .q(q4), .r(r4), .zf(zf4), .ef(ef4), .of(of4), .dzf(dzf4)
    );

    assign iry_v = sel ? iry4 : iry8;
    assign ov_v  = sel ? ov4 : ov8;
    assign q_v   = sel ? {4'h0, q4} : q8;
    assign r_v   = sel ? {4'h0, r4} : r8;
    assign fl_v  = sel ? {zf4, ef4, of4, dzf4} : {zf8, ef8, of8, dzf8};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Truncating signed-magnitude division; flags {zf, ef, of, dzf}.
    task automatic ref_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                          output logic [7:0] eq, output logic [7:0] er, output logic [3:0] efl);
        int mask, sa, sb, ma, mb, qm, rm, qi, ri;
        mask = (1 << (w - 1)) - 1;
        sa = (int'(av) >> (w - 1)) & 1;
        sb = (int'(bv) >> (w - 1)) & 1;
        ma = int'(av) & mask;
        mb = int'(bv) & mask;
        if (mb == 0) begin
            qm = 0;
            rm = ma;
        end else begin
            qm = ma / mb;
            rm = ma % mb;
        end
        qi = (qm == 0) ? 0 : (qm | ((sa ^ sb) << (w - 1)));
        ri = (rm == 0) ? 0 : (rm | (sa << (w - 1)));
        eq = 8'(qi);
        er = 8'(ri);
        efl = {rm == 0, (ri & 1) == 0, (ri & 1) == 1, mb == 0};
    endtask

    task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input int stall);
        logic [7:0] eq, er;
        logic [3:0] efl;
        int n, explat;
        ref_op(sel ? 4 : 8, av, bv, eq, er, efl);
        explat = efl[0] ? 1 : (sel ? 4 : 8);
        chk("idle_ready", 32'(iry_v), 32'd1);
        a_d = av;
        b_d = bv;
        iv  = 1'b1;
        step();
        n = 0;
        while (!ov_v && n < 40) begin
            iv  = 1'($urandom_range(0, 1));
            a_d = 8'($urandom);
            b_d = 8'($urandom);
            step();
            n++;
        end
        iv = 1'b0;
        chk("latency", 32'(n), 32'(explat));
        chk("q", 32'(q_v), 32'(eq));
        chk("r", 32'(r_v), 32'(er));
        chk("flags", 32'(fl_v), 32'(efl));
        chk("busy_ready", 32'(iry_v), 32'd0);
        for (int s = 0; s < stall; s++) begin
            step();
            chk("hold_valid", 32'(ov_v), 32'd1);
            chk("hold_q", 32'(q_v), 32'(eq));
            chk("hold_r", 32'(r_v), 32'(er));
            chk("hold_flags", 32'(fl_v), 32'(efl));
            chk("hold_ready", 32'(iry_v), 32'd0);
        end
        ordy = 1'b1;
        step();
        ordy = 1'b0;
        chk("drop_valid", 32'(ov_v), 32'd0);
        chk("ready_back", 32'(iry_v), 32'd1);
    endtask

    initial begin
        logic [7:0] ra, rb;
        bit seen;

        step();
        step();
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            chk("rst_ready", 32'(iry_v), 32'd1);
            chk("rst_valid", 32'(ov_v), 32'd0);
            chk("rst_q", 32'(q_v), 32'd0);
            chk("rst_r", 32'(r_v), 32'd0);
            chk("rst_flags", 32'(fl_v), 32'd0);
        end
        sel = 1'b0;
        rst = 1'b0;
        step();

        do_op(8'h87, 8'h02, 5);
        do_op(8'h06, 8'h83, 0);
        do_op(8'h85, 8'h80, 2);

        // Abort a division partway through CALC.
        a_d = 8'h7f;
        b_d = 8'h03;
        iv  = 1'b1;
        step();
        iv = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk("rst_mid_ready", 32'(iry_v), 32'd1);
        step();
        rst = 1'b0;
        chk("abort_valid", 32'(ov_v), 32'd0);
        chk("abort_q", 32'(q_v), 32'd0);
        chk("abort_r", 32'(r_v), 32'd0);
        chk("abort_flags", 32'(fl_v), 32'd0);
        chk("abort_ready", 32'(iry_v), 32'd1);
        seen = 1'b0;
        repeat (15) begin
            step();
            seen |= ov_v;
        end
        chk("no_stale", 32'(seen), 32'd0);

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 7) == 0) rb = {rb[7], 7'h00};
            do_op(ra, rb, $urandom_range(0, 3));
        end

        sel = 1'b1;
        #1;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                do_op(8'(x), 8'(y), $urandom_range(0, 2));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sm_divrem_seq.md
Name: sm_divrem_seq

Overview:
Parametrised, multi-cycle signed-magnitude divider returning both quotient and remainder, plus status flags ZF/EF/OF/DZF.
Successor to the 3-bit combinational remainder unit: generalised to W bits, and clocked with a valid/ready handshake.
Uses a restoring shift-subtract loop at one quotient bit per cycle.
Sits behind the calculator operand registers and feeds the result/flag display path.

Parameters:
W, 8, total operand width; bit W-1 is the sign, bits W-2..0 are the magnitude (M = W-1 magnitude bits); legal W >= 3.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operands a/b present
in_ready  out  1  block can accept operands (high only in IDLE)
a  in  W  dividend, signed-magnitude
b  in  W  divisor, signed-magnitude
out_valid  out  1  q/r/flags valid, held until taken
out_ready  in  1  consumer accepts result
q  out  W  quotient, signed-magnitude
r  out  W  remainder, signed-magnitude
zf  out  1  r magnitude == 0
ef  out  1  r even (r[0]==0)
of  out  1  r odd (r[0]==1)
dzf  out  1  divisor magnitude == 0

Behaviour:
- Single clock domain; all state on rising clk.
- Reset:
  - rst (synchronous, active-high) forces state IDLE.
  - q, r, out_valid, zf, ef, of and dzf all go to 0.
  - in_ready = 1 while rst is high and afterwards.
- rst mid-CALC or mid-DONE aborts the operation; no result is produced.
- State machine: IDLE, CALC, DONE.
  - IDLE:
    - in_ready=1.
    - On in_valid && in_ready, capture |a|, |b|, sign_a and sign_b.
    - If |b|==0, go to DONE directly.
    - Otherwise go to CALC with the step counter at M-1.
  - CALC:
    - Each cycle: shift partial remainder left, bringing in the next dividend magnitude bit (MSB first).
    - If partial >= |b|, subtract and set the quotient bit to 1; otherwise set it to 0.
    - Exactly M cycles; then load the outputs and go to DONE.
  - DONE:
    - out_valid=1; outputs are stable.
    - Back-pressure is honoured: any number of cycles with out_ready=0 leaves every output unchanged.
    - On out_ready, go to IDLE and drop out_valid the next cycle.
    - in_ready rises the cycle after the handshake; there is no same-cycle re-accept.
- Latency:
  - Accept edge = k.
  - Nonzero divisor: out_valid rises at edge k+M+1.
  - Zero divisor: out_valid rises at edge k+1.
- Arithmetic:
  - |q| = |a| div |b| and |r| = |a| mod |b|, both M bits wide.
  - sign_q = sign_a XOR sign_b; sign_r = sign_a (truncating division).
  - Negative zero: any result with zero magnitude is emitted with sign 0 (no -0 on outputs).
  - Inputs of -0 are treated as 0. A b of 0x80 (W=8) counts as divide-by-zero.
  - Overflow is impossible, since |q| <= |a|.
- Divide by zero: dzf=1, q=+0, r=a (normalised), flags computed from r.
- Flags:
  - Derived from the final r and registered together with q/r.
  - zf=1 implies ef=1.
  - ef and of are mutually exclusive and always complementary.
  - dzf=0 for every nonzero divisor.
- Inputs a and b are ignored outside the IDLE accept cycle; changing them during CALC has no effect.
- in_valid asserted while busy is not an error: it is simply not accepted.

Decomposition:
- Shared package sm_arith_pkg:
  - Helper functions sm_sign, sm_mag, sm_pack (sign+magnitude packing with -0 normalisation).
  - State enum constants ST_IDLE/ST_CALC/ST_DONE.
  - Flag bit-index constants (ZF=3, EF=2, OF=1, DZF=0) for the display/flag bus.
- One natural sub-module, sm_flag_gen: combinational r/b -> zf, ef, of, dzf.
  - Reused by the other W-parameterised ALU ops (add/sub/mul successors).

Test Plan:
- W=8, a=0x87 (-7), b=0x02 (+2) -> q=0x83 (-3), r=0x81 (-1); zf=0 ef=0 of=1 dzf=0; out_valid exactly 8 cycles after accept.
- W=8, a=0x06 (+6), b=0x83 (-3) -> q=0x82 (-2), r=0x00 (+0, not 0x80); zf=1 ef=1 of=0 dzf=0.
- W=8, a=0x85 (-5), b=0x80 (-0) -> dzf=1, q=0x00, r=0x85, of=1; out_valid 1 cycle after accept.
- Back-pressure/rst:
  - Hold out_ready=0 for 5 cycles after out_valid -> q/r/flags unchanged and in_ready=0 throughout.
  - Then release -> in_ready=1 the cycle after the handshake.
  - Separately, assert rst 3 cycles into CALC -> next cycle out_valid=0, all outputs 0, in_ready=1; no stale result appears later.
- W=4 exhaustive: all 256 (a,b) pairs, random out_ready stalls -> q/r/flags match a signed-magnitude reference model (sign of r follows a, no -0).
